// File: rtl/spi_deserializer_if.sv
// ----------------------------------------------------------------------------
// spi_deserializer_if
//   Groups the serial input pins, the receive-FIFO write port and the status
//   flags of the SPI receive stage into one bundle.
//
//   sclk         serial clock, asynchronous to clk
//   mosi         serial data, stable at the sclk rising edge
//   full         receive FIFO full
//   clr_overrun  one-cycle pulse that clears the sticky overrun flag
//   writeEn      FIFO write strobe
//   writeData    word written to the FIFO
//   busy         partial word in progress, or a word waiting to be written
//   overrun      sticky: a completed word was dropped
//   frame_err    one-cycle pulse: a partial word was discarded by the timeout
//
//   slave  : the deserializer side
//   master : the side that drives the pins and owns the FIFO
// ----------------------------------------------------------------------------
interface spi_deserializer_if #(
    parameter int DATAWIDTH = 32
);
    logic                 sclk;
    logic                 mosi;
    logic                 full;
    logic                 clr_overrun;
    logic                 writeEn;
    logic [DATAWIDTH-1:0] writeData;
    logic                 busy;
    logic                 overrun;
    logic                 frame_err;

    modport slave (
        input  sclk, mosi, full, clr_overrun,
        output writeEn, writeData, busy, overrun, frame_err
    );

    modport master (
        output sclk, mosi, full, clr_overrun,
        input  writeEn, writeData, busy, overrun, frame_err
    );
endinterface

// File: rtl/spi_deserializer.sv
// ----------------------------------------------------------------------------
// spi_deserializer
//   Receive-side SPI stage. sclk and mosi are oversampled in the clk domain and
//   DATAWIDTH-bit words are shifted in MSB-first on every sclk rising edge.
//   Each completed word is handed to the receive FIFO through a one-word output
//   buffer, so reception continues while a word waits on a full FIFO. A partial
//   word that sees no sclk rise for TIMEOUT clk cycles is dropped, which
//   realigns word boundaries with the master.
//
//   clk   system clock
//   rst   asynchronous, active-high reset
//   bus   spi_deserializer_if.slave (serial pins, FIFO write port, status)
// ----------------------------------------------------------------------------
module spi_deserializer #(
    parameter int DATAWIDTH       = 32,
    parameter int BITCOUNTERWIDTH = $clog2(DATAWIDTH),
    parameter int SYNC_STAGES     = 2,
    parameter int TIMEOUT         = 64,
    parameter int TOCNTWIDTH      = $clog2(TIMEOUT + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    spi_deserializer_if.slave      bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef logic [BITCOUNTERWIDTH:0] bitcnt_t;
    typedef logic [TOCNTWIDTH-1:0]    tocnt_t;
    typedef logic [DATAWIDTH-1:0]     word_t;

    localparam bitcnt_t LAST_BIT = bitcnt_t'(DATAWIDTH - 1);
    localparam tocnt_t  TO_LAST  = tocnt_t'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   sclk_q;
    logic                   rise;

    state_t  state, state_next;
    word_t   shift_reg, shift_next;
    bitcnt_t bit_cnt, bit_cnt_next;
    tocnt_t  to_cnt, to_cnt_next;
    word_t   shifted;
    logic    word_done;
    logic    timeout_hit;

    word_t   out_buf;
    logic    pending;
    logic    overrun;
    logic    frame_err;
    logic    write;

    // Both pins go through identical chains so the data bit sampled on a
    // detected rise is the one that was stable at the pin edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            sclk_q    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            sclk_q    <= sclk_s;
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_q;

    // The size cast drops the top bit, which also covers DATAWIDTH==1.
    assign shifted = word_t'({shift_reg, mosi_s});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt_next;
            to_cnt    <= to_cnt_next;
            frame_err <= timeout_hit;
        end
    end

    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt;
        to_cnt_next  = to_cnt;
        word_done    = 1'b0;
        timeout_hit  = 1'b0;

        if (rise) begin
            to_cnt_next = '0;
            // In IDLE bit_cnt is 0, so a one-bit word completes on its first rise.
            if (bit_cnt == LAST_BIT) begin
                word_done    = 1'b1;
                shift_next   = '0;
                bit_cnt_next = '0;
                state_next   = IDLE;
            end else begin
                shift_next   = shifted;
                bit_cnt_next = bit_cnt + 1'b1;
                state_next   = SHIFT;
            end
        end else begin
            case (state)
                IDLE: begin
                    to_cnt_next = '0;
                end
                SHIFT: begin
                    if (to_cnt == TO_LAST) begin
                        timeout_hit  = 1'b1;
                        shift_next   = '0;
                        bit_cnt_next = '0;
                        to_cnt_next  = '0;
                        state_next   = IDLE;
                    end else begin
                        to_cnt_next = to_cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign write = pending & ~bus.full;

    // A completing word may replace the buffered one only in the cycle that
    // buffered word is being written; otherwise the new word is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_buf <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (word_done) begin
                if (!pending || write) begin
                    out_buf <= shifted;
                    pending <= 1'b1;
                end
            end else if (write) begin
                pending <= 1'b0;
            end

            if (word_done && pending && !write) begin
                overrun <= 1'b1;
            end else if (bus.clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    assign bus.writeEn   = write;
    assign bus.writeData = out_buf;
    assign bus.busy      = (state == SHIFT) | pending;
    assign bus.overrun   = overrun;
    assign bus.frame_err = frame_err;

endmodule

// File: tb/tb_spi_deserializer.sv
// ----------------------------------------------------------------------------
// tb_spi_deserializer
//   Directed bench for spi_deserializer (DATAWIDTH=32, SYNC_STAGES=2,
//   TIMEOUT=64). A monitor logs every FIFO write and counts frame_err cycles;
//   the main sequence compares those logs and the status outputs against
//   hand-computed values.
// ----------------------------------------------------------------------------
module tb_spi_deserializer;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    logic [31:0] wordLog[$];
    int          frameErrCycles = 0;

    spi_deserializer_if #(.DATAWIDTH(32)) bus ();

    spi_deserializer #(
        .DATAWIDTH  (32),
        .SYNC_STAGES(2),
        .TIMEOUT    (64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.writeEn === 1'b1) wordLog.push_back(bus.writeData);
            if (bus.frame_err === 1'b1) frameErrCycles++;
        end
    end

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] loggedWord(input int idx);
        if (idx < wordLog.size()) return wordLog[idx];
        return 32'hxxxxxxxx;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Sends the top nbits of word MSB-first, sclk period 8 clk (4 low, 4 high).
    // hook 1 drops full, hook 2 pulses clr_overrun, exactly in the cycle the
    // final rise is seen after the two-flop synchroniser.
    task automatic applyStimulus(input logic [31:0] word, input int nbits, input int hook);
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = word[31-i];
            bus.sclk = 1'b0;
            idleCycles(4);
            bus.sclk = 1'b1;
            if (i == nbits - 1 && hook != 0) begin
                idleCycles(2);
                if (hook == 1) bus.full = 1'b0;
                else           bus.clr_overrun = 1'b1;
                idleCycles(1);
                bus.clr_overrun = 1'b0;
                idleCycles(1);
            end else begin
                idleCycles(4);
            end
        end
        bus.sclk = 1'b0;
        idleCycles(4);
    endtask

    initial begin
        rst             = 1'b1;
        bus.sclk        = 1'b0;
        bus.mosi        = 1'b0;
        bus.full        = 1'b0;
        bus.clr_overrun = 1'b0;
        idleCycles(3);

        checkOutput("reset_writeEn",   {31'd0, bus.writeEn},   32'd0);
        checkOutput("reset_writeData", bus.writeData,          32'd0);
        checkOutput("reset_busy",      {31'd0, bus.busy},      32'd0);
        checkOutput("reset_overrun",   {31'd0, bus.overrun},   32'd0);
        checkOutput("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
        rst = 1'b0;
        idleCycles(2);

        $display("[TB] test 1: single word");
        applyStimulus(32'hA5A55AC3, 32, 0);
        idleCycles(2);
        checkOutput("t1_write_count", wordLog.size(),         32'd1);
        checkOutput("t1_word",        loggedWord(0),          32'hA5A55AC3);
        checkOutput("t1_overrun",     {31'd0, bus.overrun},   32'd0);
        checkOutput("t1_busy",        {31'd0, bus.busy},      32'd0);

        $display("[TB] test 2: overrun on full FIFO");
        bus.full = 1'b1;
        applyStimulus(32'h11111111, 32, 0);
        applyStimulus(32'h22222222, 32, 0);
        checkOutput("t2_no_write_while_full", wordLog.size(),       32'd1);
        checkOutput("t2_overrun",             {31'd0, bus.overrun}, 32'd1);
        checkOutput("t2_busy_pending",        {31'd0, bus.busy},    32'd1);
        bus.full = 1'b0;
        idleCycles(3);
        checkOutput("t2_write_count", wordLog.size(),    32'd2);
        checkOutput("t2_word",        loggedWord(1),     32'h11111111);
        idleCycles(20);
        checkOutput("t2_second_dropped", wordLog.size(), 32'd2);
        checkOutput("t2_busy_idle",   {31'd0, bus.busy}, 32'd0);
        bus.clr_overrun = 1'b1;
        idleCycles(1);
        bus.clr_overrun = 1'b0;
        checkOutput("t2_overrun_cleared", {31'd0, bus.overrun}, 32'd0);

        $display("[TB] test 3: timeout realignment");
        applyStimulus(32'hABC00000, 12, 0);
        checkOutput("t3_busy_partial", {31'd0, bus.busy}, 32'd1);
        idleCycles(80);
        checkOutput("t3_frame_err_cycles", frameErrCycles,    32'd1);
        checkOutput("t3_no_write",         wordLog.size(),    32'd2);
        checkOutput("t3_busy_after",       {31'd0, bus.busy}, 32'd0);
        applyStimulus(32'hDEADBEEF, 32, 0);
        idleCycles(2);
        checkOutput("t3_write_count", wordLog.size(), 32'd3);
        checkOutput("t3_word",        loggedWord(2),  32'hDEADBEEF);

        $display("[TB] test 4: full released on completion cycle");
        bus.full = 1'b1;
        applyStimulus(32'h12345678, 32, 0);
        applyStimulus(32'h9ABCDEF0, 32, 1);
        idleCycles(3);
        checkOutput("t4_write_count", wordLog.size(),       32'd5);
        checkOutput("t4_word_first",  loggedWord(3),        32'h12345678);
        checkOutput("t4_word_second", loggedWord(4),        32'h9ABCDEF0);
        checkOutput("t4_overrun",     {31'd0, bus.overrun}, 32'd0);

        $display("[TB] test 5: reset mid-word");
        applyStimulus(32'hFFC00000, 10, 0);
        rst = 1'b1;
        #1;
        checkOutput("t5_writeEn",   {31'd0, bus.writeEn},   32'd0);
        checkOutput("t5_writeData", bus.writeData,          32'd0);
        checkOutput("t5_busy",      {31'd0, bus.busy},      32'd0);
        checkOutput("t5_overrun",   {31'd0, bus.overrun},   32'd0);
        checkOutput("t5_frame_err", {31'd0, bus.frame_err}, 32'd0);
        idleCycles(3);
        rst = 1'b0;
        idleCycles(4);
        applyStimulus(32'h0000FFFF, 32, 0);
        idleCycles(2);
        checkOutput("t5_write_count", wordLog.size(), 32'd6);
        checkOutput("t5_word",        loggedWord(5),  32'h0000FFFF);
        checkOutput("t5_no_frame_err", frameErrCycles, 32'd1);

        $display("[TB] test 6: overrun set beats clear");
        bus.full = 1'b1;
        applyStimulus(32'h5555AAAA, 32, 0);
        checkOutput("t6_overrun_before", {31'd0, bus.overrun}, 32'd0);
        applyStimulus(32'h0F0F0F0F, 32, 2);
        checkOutput("t6_overrun_set", {31'd0, bus.overrun}, 32'd1);
        idleCycles(3);
        checkOutput("t6_overrun_sticky", {31'd0, bus.overrun}, 32'd1);
        bus.clr_overrun = 1'b1;
        idleCycles(1);
        bus.clr_overrun = 1'b0;
        checkOutput("t6_overrun_cleared", {31'd0, bus.overrun}, 32'd0);
        bus.full = 1'b0;
        idleCycles(3);
        checkOutput("t6_write_count", wordLog.size(), 32'd7);
        checkOutput("t6_word",        loggedWord(6),  32'h5555AAAA);
        idleCycles(20);
        checkOutput("t6_dropped_word_absent", wordLog.size(), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
